vrf_wb_arbiter: RTL and testbench
=================================

// Module: vrf_wb_arbiter
// PURPOSE
// Per-lane VRF write-back arbiter. It collects result-write requests from the lane's VFUs
// (VALU, VMUL, VLSU) and resolves conflicts on the single-write-port VRF SRAM banks.
// Grants are returned in the same cycle; the chosen write is registered toward the bank.
// Sits between each VFU result buffer (valid/gnt handshake) and the VRF banks in vrf_accesser.
// PARAMETERS
// NrSrc   3  number of write requesters; index 0=VALU, 1=VMUL, 2=VLSU
// NrBank  4  number of VRF banks (power of 2); bank = waddr[LogNrBank-1:0]
// PORTS
// clk_i          in   1                        clock
// rst_i          in   1                        synchronous reset, active-high
// wr_valid_i     in   NrSrc                    source holds a pending write
// wr_gnt_o       out  NrSrc                    write accepted this cycle (source pops on it)
// wr_addr_i      in   NrSrc x vrf_addr_t       VRF word address
// wr_data_i      in   NrSrc x vrf_data_t       write data
// wr_strb_i      in   NrSrc x vrf_strb_t       byte enables
// wr_id_i        in   NrSrc x insn_id_t        instruction id
// bank_busy_i    in   NrBank                   bank port taken by a read this cycle
// bank_we_o      out  NrBank                   registered write enable
// bank_addr_o    out  NrBank x vrf_baddr_t     bank-local address, waddr >> LogNrBank
// bank_wdata_o   out  NrBank x vrf_data_t      write data
// bank_wstrb_o   out  NrBank x vrf_strb_t      byte enables
// wb_valid_o     out  NrSrc                    write reached the bank (1 cycle after gnt)
// wb_id_o        out  NrSrc x insn_id_t        id of that write
// BEHAVIOUR
// - Request vector: src s targets bank b when wr_valid_i[s] && wr_addr_i[s][LogNrBank-1:0]==b.
// - Per-bank grant: when bank_busy_i[b]==1, nothing is granted on bank b.
//   Otherwise exactly one requester is granted, using round-robin from rr_q[b].
// - wr_gnt_o is purely combinational from the inputs and rr_q. It never asserts without wr_valid_i.
// - A source targets only one bank per cycle, so it receives at most one grant per cycle.
// - rr_q[b] (clog2(NrSrc) bits) is updated only on a grant: it becomes (granted_src+1) mod NrSrc.
//   The wrap is explicit, since NrSrc need not be a power of 2.
// - Output stage (1-cycle latency): on a grant in cycle N, bank_we_o/addr/wdata/wstrb of bank b
//   carry that write in cycle N+1. In the same cycle N+1, wb_valid_o[s]=1 with wb_id_o[s]=wr_id_i[s].
//   With no grant, bank_we_o[b]=0 and wb_valid_o[s]=0. Data, addr and id registers hold their values.
// - Back-to-back grants to one bank on consecutive cycles are legal (full throughput per bank).
// - All NrBank banks may write in the same cycle.
// - A source keeps valid/addr/data/id stable until granted; the arbiter relies on it, with no re-sampling.
// - Reset (sync, rst_i=1): bank_we_o=0, wb_valid_o=0, rr_q=0; addr/data/strb/id regs are not reset.
//   wr_gnt_o is forced to 0 while rst_i=1.
// - Reset mid-operation: any write registered but not yet presented is dropped, i.e. bank_we_o=0
//   on the cycle after reset is sampled. Upstream VFUs are reset by the same rst_i.
// - Starvation bound (round-robin): a continuously valid source waits at most NrSrc-1 non-busy
//   cycles of its bank.
// CONFIGURATION
// - VRF_WB_FIXED_PRIO_EN defined: fixed priority replaces round-robin. The lowest source index wins
//   (VALU > VMUL > VLSU), and rr_q is not instantiated. A lower-priority source may starve; it is
//   then the caller's responsibility.
// - Undefined (default): round-robin as above.
// STRUCTURE
// - core_pkg additions: NrVRFBank, LogNrVRFBank, vrf_baddr_t = logic [VRFAddrWidth-LogNrVRFBank-1:0].
//   The block reuses vrf_addr_t, vrf_data_t, vrf_strb_t and insn_id_t.
// - One sub-module, rr_picker #(N): req[N], ptr -> onehot gnt, gnt_idx.
//   It has a fixed-priority mode under the same macro. There is one instance per bank (gen_bank loop).
// - The output register is per bank; wb_valid_o/wb_id_o registers are per source.
// TESTING
// - Reset then idle: all outputs 0 for 5 cycles; with rst_i=1 and wr_valid_i=3'b111, wr_gnt_o=0.
// - Single source: VALU writes addr 0x05 (bank 1), data 0xDEAD, strb 0xFF -> gnt same cycle.
//   Next cycle: bank_we_o=4'b0010, bank_addr_o[1]=0x01, wb_valid_o[0]=1 with its id.
// - Conflict: all 3 sources hold bank 2 for 6 cycles -> grant order 0,1,2,0,1,2.
//   Under VRF_WB_FIXED_PRIO_EN the order is 0,0,0,... and sources 1,2 are never granted.
// - Parallel: sources hit banks 0,1,3 in the same cycle -> all 3 granted.
//   Next cycle bank_we_o=4'b1011 with the matching data on each bank.
// - Busy: bank_busy_i[2]=1 for 3 cycles while VMUL targets bank 2 -> no grant.
//   Granted on the first busy=0 cycle; write appears 1 cycle later.
// - Reset mid-stream: assert rst_i on the cycle after a grant -> bank_we_o=0 next cycle, and rr_q=0
//   (the next conflict grants source 0 first).

Source files
------------

// File: rtl/vrf_wb_arbiter_pkg.sv
// Sizing, types and helpers shared by the VRF write-back arbiter slice.
// Build option: define VRF_WB_FIXED_PRIO_EN for fixed-priority arbitration.
package vrf_wb_arbiter_pkg;

   localparam int unsigned NrSrc        = 3;  // 0=VALU, 1=VMUL, 2=VLSU
   localparam int unsigned SrcIdxWidth  = $clog2(NrSrc);
   localparam int unsigned NrVRFBank    = 4;
   localparam int unsigned LogNrVRFBank = $clog2(NrVRFBank);
   localparam int unsigned VRFAddrWidth = 8;
   localparam int unsigned VRFDataWidth = 64;
   localparam int unsigned VRFStrbWidth = VRFDataWidth / 8;
   localparam int unsigned InsnIdWidth  = 3;

   typedef logic [VRFAddrWidth-1:0]              vrf_addr_t;
   typedef logic [VRFAddrWidth-LogNrVRFBank-1:0] vrf_baddr_t;
   typedef logic [VRFDataWidth-1:0]              vrf_data_t;
   typedef logic [VRFStrbWidth-1:0]              vrf_strb_t;
   typedef logic [InsnIdWidth-1:0]               insn_id_t;
   typedef logic [SrcIdxWidth-1:0]               src_idx_t;
   typedef logic [LogNrVRFBank-1:0]              bank_idx_t;

   typedef struct packed {
      vrf_baddr_t baddr;
      vrf_data_t  data;
      vrf_strb_t  strb;
   } bank_wr_t;

   function automatic bank_idx_t bank_of(vrf_addr_t addr);
      return addr[LogNrVRFBank-1:0];
   endfunction

   function automatic vrf_baddr_t baddr_of(vrf_addr_t addr);
      return addr[VRFAddrWidth-1:LogNrVRFBank];
   endfunction

   // NrSrc need not be a power of two, so the wrap is explicit.
   function automatic src_idx_t next_src(src_idx_t s);
      return (s == src_idx_t'(NrSrc - 1)) ? '0 : s + src_idx_t'(1);
   endfunction

endpackage

// File: rtl/vrf_wb_arbiter_if.sv
// Write-back bus between the lane VFUs / VRF banks (master) and the arbiter (slave).
// Build option VRF_WB_FIXED_PRIO_EN does not change this interface.
interface vrf_wb_arbiter_if;
   import vrf_wb_arbiter_pkg::*;

   logic [NrSrc-1:0]     wr_valid;
   logic [NrSrc-1:0]     wr_gnt;
   vrf_addr_t            wr_addr  [NrSrc];
   vrf_data_t            wr_data  [NrSrc];
   vrf_strb_t            wr_strb  [NrSrc];
   insn_id_t             wr_id    [NrSrc];
   logic [NrVRFBank-1:0] bank_busy;
   logic [NrVRFBank-1:0] bank_we;
   vrf_baddr_t           bank_addr  [NrVRFBank];
   vrf_data_t            bank_wdata [NrVRFBank];
   vrf_strb_t            bank_wstrb [NrVRFBank];
   logic [NrSrc-1:0]     wb_valid;
   insn_id_t             wb_id    [NrSrc];

   modport master (
      output wr_valid, wr_addr, wr_data, wr_strb, wr_id, bank_busy,
      input  wr_gnt, bank_we, bank_addr, bank_wdata, bank_wstrb, wb_valid, wb_id
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_strb, wr_id, bank_busy,
      output wr_gnt, bank_we, bank_addr, bank_wdata, bank_wstrb, wb_valid, wb_id
   );

endinterface

// File: rtl/vrf_wb_arbiter_rr_picker.sv
// Round-robin one-hot picker starting at i_ptr; lowest-index-wins when
// VRF_WB_FIXED_PRIO_EN is defined (the pointer port then disappears).
module vrf_wb_arbiter_rr_picker #(
   parameter int unsigned N    = 3,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
`ifndef VRF_WB_FIXED_PRIO_EN
   input  logic [IdxW-1:0] i_ptr,
`endif
   input  logic [N-1:0]    i_req,
   output logic [N-1:0]    o_gnt,
   output logic [IdxW-1:0] o_gnt_idx
);

   always_comb begin
      logic w_found;
      w_found   = 1'b0;
      o_gnt     = '0;
      o_gnt_idx = '0;
`ifndef VRF_WB_FIXED_PRIO_EN
      // First pass scans [ptr, N); the shared pass below then wraps to [0, ptr).
      for (int unsigned i = 0; i < N; i++) begin
         if (!w_found && i_req[i] && (i >= 32'(i_ptr))) begin
            w_found   = 1'b1;
            o_gnt[i]  = 1'b1;
            o_gnt_idx = IdxW'(i);
         end
      end
`endif
      for (int unsigned i = 0; i < N; i++) begin
         if (!w_found && i_req[i]) begin
            w_found   = 1'b1;
            o_gnt[i]  = 1'b1;
            o_gnt_idx = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Per-lane VRF write-back arbiter: same-cycle grants, one registered write per bank.
// Build option: VRF_WB_FIXED_PRIO_EN selects fixed priority (VALU > VMUL > VLSU).
module vrf_wb_arbiter
   import vrf_wb_arbiter_pkg::*;
(
   input logic             clk_i,
   input logic             rst_i,
   vrf_wb_arbiter_if.slave bus
);

   logic [NrSrc-1:0]     w_req      [NrVRFBank];
   logic [NrSrc-1:0]     w_bank_gnt [NrVRFBank];
   src_idx_t             w_gnt_idx  [NrVRFBank];
   bank_wr_t             w_sel      [NrVRFBank];
   logic [NrVRFBank-1:0] w_bank_any;
   logic [NrSrc-1:0]     w_src_gnt;

   logic [NrVRFBank-1:0] r_bank_we;
   bank_wr_t             r_bank_wr [NrVRFBank];
   logic [NrSrc-1:0]     r_wb_valid;
   insn_id_t             r_wb_id   [NrSrc];
`ifndef VRF_WB_FIXED_PRIO_EN
   src_idx_t             r_rr      [NrVRFBank];
`endif

   // Busy banks and reset are folded into the request so grants can never leak out.
   always_comb begin
      for (int b = 0; b < NrVRFBank; b++) begin
         for (int s = 0; s < NrSrc; s++) begin
            w_req[b][s] = bus.wr_valid[s] && !bus.bank_busy[b] && !rst_i &&
                          (bank_of(bus.wr_addr[s]) == bank_idx_t'(b));
         end
      end
   end

   for (genvar b = 0; b < NrVRFBank; b++) begin : gen_bank
      vrf_wb_arbiter_rr_picker #(
         .N    (NrSrc),
         .IdxW (SrcIdxWidth)
      ) u_picker (
`ifndef VRF_WB_FIXED_PRIO_EN
         .i_ptr     (r_rr[b]),
`endif
         .i_req     (w_req[b]),
         .o_gnt     (w_bank_gnt[b]),
         .o_gnt_idx (w_gnt_idx[b])
      );
   end

   always_comb begin
      w_src_gnt = '0;
      for (int b = 0; b < NrVRFBank; b++) begin
         w_bank_any[b] = |w_bank_gnt[b];
         w_src_gnt     = w_src_gnt | w_bank_gnt[b];
         w_sel[b]      = '{baddr: baddr_of(bus.wr_addr[w_gnt_idx[b]]),
                           data:  bus.wr_data[w_gnt_idx[b]],
                           strb:  bus.wr_strb[w_gnt_idx[b]]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bank_we  <= '0;
         r_wb_valid <= '0;
`ifndef VRF_WB_FIXED_PRIO_EN
         for (int b = 0; b < NrVRFBank; b++) r_rr[b] <= '0;
`endif
      end else begin
         r_bank_we  <= w_bank_any;
         r_wb_valid <= w_src_gnt;
`ifndef VRF_WB_FIXED_PRIO_EN
         for (int b = 0; b < NrVRFBank; b++) begin
            if (w_bank_any[b]) r_rr[b] <= next_src(w_gnt_idx[b]);
         end
`endif
      end
   end

   // Payload registers are not reset; they only load on a grant.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NrVRFBank; b++) begin
         if (w_bank_any[b]) r_bank_wr[b] <= w_sel[b];
      end
      for (int s = 0; s < NrSrc; s++) begin
         if (w_src_gnt[s]) r_wb_id[s] <= bus.wr_id[s];
      end
   end

   assign bus.wr_gnt   = w_src_gnt;
   assign bus.bank_we  = r_bank_we;
   assign bus.wb_valid = r_wb_valid;

   always_comb begin
      for (int b = 0; b < NrVRFBank; b++) begin
         bus.bank_addr[b]  = r_bank_wr[b].baddr;
         bus.bank_wdata[b] = r_bank_wr[b].data;
         bus.bank_wstrb[b] = r_bank_wr[b].strb;
      end
      for (int s = 0; s < NrSrc; s++) bus.wb_id[s] = r_wb_id[s];
   end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Scoreboard bench for vrf_wb_arbiter: directed scenarios then randomized traffic.
// Build option VRF_WB_FIXED_PRIO_EN switches the reference model to fixed priority.
module tb_vrf_wb_arbiter;
   import vrf_wb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vrf_wb_arbiter_if bus ();

   vrf_wb_arbiter dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      int         cyc;
      int         idx;
      vrf_baddr_t a;
      vrf_data_t  d;
      vrf_strb_t  st;
      insn_id_t   id;
   } exp_t;

   exp_t bank_q[$];
   exp_t wb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   id_ctr   = 0;

   // Reference model: pending request per source, round-robin pointer per bank.
   bit        p_v  [NrSrc];
   vrf_addr_t p_a  [NrSrc];
   vrf_data_t p_d  [NrSrc];
   vrf_strb_t p_s  [NrSrc];
   insn_id_t  p_id [NrSrc];
   int        rr   [NrVRFBank];
   logic [NrSrc-1:0] dut_gnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [127:0] act, logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic load(int s, int unsigned addr, vrf_data_t d, vrf_strb_t st);
      p_v[s]  = 1'b1;
      p_a[s]  = vrf_addr_t'(addr);
      p_d[s]  = d;
      p_s[s]  = st;
      p_id[s] = insn_id_t'(id_ctr);
      id_ctr++;
   endtask

   task automatic load_rand(int s, int bank);
      load(s, ($urandom_range(0, 63) << 2) | bank, {$urandom, $urandom}, vrf_strb_t'($urandom));
   endtask

   function automatic bit any_pend();
      bit r = 1'b0;
      for (int s = 0; s < NrSrc; s++) r |= p_v[s];
      return r;
   endfunction

   task automatic run_cycle(logic [NrVRFBank-1:0] busy, bit do_rst);
      logic [NrSrc-1:0] exp_g;
      int bank;
      int s;
      @(posedge clk);
      #1;
      rst            = do_rst;
      bus.bank_busy  = busy;
      for (int i = 0; i < NrSrc; i++) begin
         bus.wr_valid[i] = p_v[i];
         bus.wr_addr[i]  = p_a[i];
         bus.wr_data[i]  = p_d[i];
         bus.wr_strb[i]  = p_s[i];
         bus.wr_id[i]    = p_id[i];
      end
      @(negedge clk);
      exp_g = '0;
      if (!do_rst) begin
         for (int b = 0; b < NrVRFBank; b++) begin
            if (!busy[b]) begin
               for (int k = 0; k < NrSrc; k++) begin
                  s = (rr[b] + k) % NrSrc;
                  if (p_v[s] && (int'(p_a[s]) % NrVRFBank == b) && !exp_g[s]) begin
                     exp_g[s] = 1'b1;
                     break;
                  end
               end
            end
         end
      end
      dut_gnt = bus.wr_gnt;
      check("wr_gnt", dut_gnt, exp_g);
      for (int i = 0; i < NrSrc; i++) begin
         if (exp_g[i]) begin
            bank = int'(p_a[i]) % NrVRFBank;
            bank_q.push_back('{cyc + 1, bank, vrf_baddr_t'(int'(p_a[i]) / NrVRFBank),
                               p_d[i], p_s[i], '0});
            wb_q.push_back('{cyc + 1, i, '0, '0, '0, p_id[i]});
`ifdef VRF_WB_FIXED_PRIO_EN
            rr[bank] = 0;
`else
            rr[bank] = (i + 1) % NrSrc;
`endif
            p_v[i] = 1'b0;
         end
      end
      if (do_rst) begin
         for (int b = 0; b < NrVRFBank; b++) rr[b] = 0;
         for (int i = 0; i < NrSrc; i++) p_v[i] = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && any_pend(); i++) run_cycle('0, 1'b0);
      check("drain_pending", 128'(any_pend()), 128'(0));
   endtask

   // Monitor: pops everything due this cycle and compares the registered outputs.
   logic [NrVRFBank-1:0] m_we;
   logic [NrSrc-1:0]     m_wv;
   vrf_baddr_t           m_a  [NrVRFBank];
   vrf_data_t            m_d  [NrVRFBank];
   vrf_strb_t            m_st [NrVRFBank];
   insn_id_t             m_id [NrSrc];
   exp_t                 m_e;

   always @(negedge clk) begin
      m_we = '0;
      m_wv = '0;
      while (bank_q.size() > 0 && bank_q[0].cyc <= cyc) begin
         m_e = bank_q.pop_front();
         m_we[m_e.idx] = 1'b1;
         m_a[m_e.idx]  = m_e.a;
         m_d[m_e.idx]  = m_e.d;
         m_st[m_e.idx] = m_e.st;
      end
      while (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
         m_e = wb_q.pop_front();
         m_wv[m_e.idx] = 1'b1;
         m_id[m_e.idx] = m_e.id;
      end
      check("bank_we", bus.bank_we, m_we);
      for (int b = 0; b < NrVRFBank; b++) begin
         if (m_we[b]) begin
            check("bank_write", {bus.bank_addr[b], bus.bank_wdata[b], bus.bank_wstrb[b]},
                  {m_a[b], m_d[b], m_st[b]});
         end
      end
      check("wb_valid", bus.wb_valid, m_wv);
      for (int s = 0; s < NrSrc; s++) begin
         if (m_wv[s]) check("wb_id", bus.wb_id[s], m_id[s]);
      end
   end

   int exp_order [6];

   initial begin
`ifdef VRF_WB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 0, 1, 2};
`endif
      bus.wr_valid  = '0;
      bus.bank_busy = '0;
      for (int s = 0; s < NrSrc; s++) begin
         bus.wr_addr[s] = '0;
         bus.wr_data[s] = '0;
         bus.wr_strb[s] = '0;
         bus.wr_id[s]   = '0;
         p_v[s]         = 1'b0;
      end
      for (int b = 0; b < NrVRFBank; b++) rr[b] = 0;

      // Reset with every source requesting, then idle.
      for (int s = 0; s < NrSrc; s++) load_rand(s, s);
      run_cycle('0, 1'b1);
      run_cycle('0, 1'b1);
      repeat (5) run_cycle('0, 1'b0);

      // Single VALU write to bank 1.
      load(0, 'h05, 64'hDEAD, 8'hFF);
      run_cycle('0, 1'b0);
      repeat (2) run_cycle('0, 1'b0);

      // Three-way conflict on bank 2.
      for (int i = 0; i < 6; i++) begin
         for (int s = 0; s < NrSrc; s++) if (!p_v[s]) load_rand(s, 2);
         run_cycle('0, 1'b0);
         check("conflict_order", dut_gnt, 3'b001 << exp_order[i]);
      end
      drain();

      // Parallel writes to banks 0, 1 and 3.
      load_rand(0, 0);
      load_rand(1, 1);
      load_rand(2, 3);
      run_cycle('0, 1'b0);
      run_cycle('0, 1'b0);

      // VMUL waits while bank 2 is busy.
      load_rand(1, 2);
      repeat (3) run_cycle(4'b0100, 1'b0);
      run_cycle('0, 1'b0);
      repeat (2) run_cycle('0, 1'b0);

      // Reset the cycle after a grant; pointer must restart at source 0.
      load_rand(0, 0);
      run_cycle('0, 1'b0);
      for (int s = 0; s < NrSrc; s++) load_rand(s, 1);
      run_cycle('0, 1'b1);
      for (int s = 0; s < NrSrc; s++) load_rand(s, 1);
      run_cycle('0, 1'b0);
      check("rst_rr_first", dut_gnt, 3'b001);
      drain();

      // Randomized traffic with busy banks and occasional reset.
      for (int i = 0; i < 400; i++) begin
         logic [NrVRFBank-1:0] busy;
         for (int b = 0; b < NrVRFBank; b++) busy[b] = ($urandom_range(0, 3) == 0);
         for (int s = 0; s < NrSrc; s++) begin
            if (!p_v[s] && $urandom_range(0, 1) == 1) load_rand(s, $urandom_range(0, 3));
         end
         run_cycle(busy, $urandom_range(0, 63) == 0);
      end
      drain();
      for (int i = 0; i < 10 && (bank_q.size() > 0 || wb_q.size() > 0); i++) run_cycle('0, 1'b0);
      run_cycle('0, 1'b0);
      check("queues_empty", 128'(bank_q.size() + wb_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
